hazard_stall_controller: RTL

- Pipeline sequencing controller for the 5-stage MIPS core.
- Decides when PC and IF/ID hold, when ID/EX gets a bubble, and when IF/ID is flushed.
- Covers hazards the forwarding paths cannot resolve: load-use, branch-in-ID operand dependencies, and a multi-cycle multiply/divide unit (MDU) with busy tracking.

---
 rtl/hazard_stall_controller_pkg.sv | 37 +++
 rtl/hazard_stall_controller_mdu_busy_tracker.sv | 73 +++++++
 rtl/hazard_stall_controller.sv | 121 ++++++++++++
 3 files changed

// File: rtl/hazard_stall_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared definitions for the pipeline hazard / stall controller.
//               Holds the MDU tracker state encoding, the hard-wired zero
//               register index, the default MDU latency and a helper that
//               compares a producer destination against the ID-stage sources.
// Macros      : none
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    // MDU busy-tracker states
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdu_state_t;

    // Register $0 is hard-wired to zero, so it never carries a dependency
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Default number of cycles the MDU stays busy after an issue
    localparam int MDU_LATENCY_DEF = 32;

    // True when producer destination r feeds a source operand of the ID
    // instruction. A destination of $0 is never a real dependency.
    function automatic logic reg_match(
        input logic [4:0] r,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       uses_rt
    );
        return (r != REG_ZERO) && ((r == rs) || (uses_rt && (r == rt)));
    endfunction

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/hazard_stall_controller_mdu_busy_tracker.sv
`default_nettype none
// ============================================================================
// Module      : mdu_busy_tracker
// Description : Tracks an in-flight multi-cycle multiply/divide operation.
//               A start that actually issues loads a down-counter with
//               MDU_LATENCY-1; busy is high from the cycle after issue for
//               exactly MDU_LATENCY cycles.
// Ports       : clk    - core clock
//               rst_n  - synchronous active-low reset
//               start  - ID instruction is mult/div
//               issue  - ID instruction leaves ID this cycle (not stalled)
//               busy   - registered, MDU operation in flight
// Macros      : none
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_busy_tracker
    import hazard_pkg::*;
#(
    parameter int MDU_LATENCY = MDU_LATENCY_DEF,
    parameter int CNT_W       = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic issue,
    output logic busy
);

    localparam logic [CNT_W-1:0] C_LOAD = CNT_W'(MDU_LATENCY - 1);

    mdu_state_t       r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_busy;

    // Single registered FSM; busy is a registered copy of (state == BUSY)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_count <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start && issue) begin
                        r_state <= BUSY;
                        r_count <= C_LOAD;
                        r_busy  <= 1'b1;
                    end
                end
                BUSY: begin
                    // The terminal count cycle is still a busy cycle; a
                    // start seen here is stalled by the top and issues from
                    // IDLE on the following cycle.
                    if (r_count == '0) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_count <= r_count - CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_count <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;

endmodule : mdu_busy_tracker
`default_nettype wire

// File: rtl/hazard_stall_controller.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stall_controller
// Description : Pipeline sequencing controller for the 5-stage MIPS core.
//               Detects hazards the forwarding network cannot cover
//               (load-use, branch-in-ID operand dependencies, MDU busy) and
//               drives PC / IF-ID hold, ID-EX bubble and IF-ID flush.
// Ports       : clk, rst_n          - clock, synchronous active-low reset
//               IF_ID_rs/rt         - ID-stage source registers
//               ID_uses_rt          - ID instruction reads rt
//               ID_branch/_taken    - beq/bne in ID and its outcome
//               ID_mdu_start        - mult/div in ID
//               ID_hilo_read        - mfhi/mflo in ID
//               ID_EX_dest/_reg_write/_mem_read - EX-stage producer
//               EX_MEM_rd/_mem_read - MEM-stage producer
//               pc_write, if_id_write, id_ex_bubble, if_id_flush, mdu_busy
//               perf_stall_cycles, perf_flushes (HAZARD_PERF_CNT_EN only)
// Macros      : HAZARD_PERF_CNT_EN - adds saturating stall/flush counters
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_stall_controller
    import hazard_pkg::*;
#(
    parameter int MDU_LATENCY = MDU_LATENCY_DEF,
    parameter int CNT_W       = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  IF_ID_rs,
    input  logic [4:0]  IF_ID_rt,
    input  logic        ID_uses_rt,
    input  logic        ID_branch,
    input  logic        ID_branch_taken,
    input  logic        ID_mdu_start,
    input  logic        ID_hilo_read,
    input  logic [4:0]  ID_EX_dest,
    input  logic        ID_EX_reg_write,
    input  logic        ID_EX_mem_read,
    input  logic [4:0]  EX_MEM_rd,
    input  logic        EX_MEM_mem_read,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        id_ex_bubble,
    output logic        if_id_flush,
    output logic        mdu_busy
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flushes
`endif
);

    logic w_ex_match;
    logic w_mem_match;
    logic w_load_use;
    logic w_br_ex;
    logic w_br_mem;
    logic w_mdu_stall;
    logic w_stall;
    logic w_flush;
    logic w_mdu_busy;

    assign w_ex_match  = reg_match(ID_EX_dest, IF_ID_rs, IF_ID_rt, ID_uses_rt);
    assign w_mem_match = reg_match(EX_MEM_rd,  IF_ID_rs, IF_ID_rt, ID_uses_rt);

    // Load data only exists after MEM, so an EX-stage load cannot forward
    assign w_load_use  = ID_EX_mem_read && w_ex_match;
    // Branches compare in ID, ahead of the EX result and the MEM load data
    assign w_br_ex     = ID_branch && ID_EX_reg_write && w_ex_match;
    assign w_br_mem    = ID_branch && EX_MEM_mem_read && w_mem_match;
    // One MDU op at a time; HI/LO are not valid until the op completes
    assign w_mdu_stall = w_mdu_busy && (ID_mdu_start || ID_hilo_read);

    assign w_stall = w_load_use || w_br_ex || w_br_mem || w_mdu_stall;

    // Flush is derived from stall, never the reverse, so no loop exists
    assign w_flush = ID_branch && ID_branch_taken && !w_stall;

    // While in reset the pipeline is frozen and fed bubbles
    assign pc_write     = rst_n && !w_stall;
    assign if_id_write  = rst_n && !w_stall;
    assign id_ex_bubble = !rst_n || w_stall;
    assign if_id_flush  = rst_n && w_flush;
    assign mdu_busy     = w_mdu_busy;

    mdu_busy_tracker #(
        .MDU_LATENCY (MDU_LATENCY),
        .CNT_W       (CNT_W)
    ) u_mdu_busy_tracker (
        .clk   (clk),
        .rst_n (rst_n),
        .start (ID_mdu_start),
        .issue (!w_stall),
        .busy  (w_mdu_busy)
    );

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_perf_stall_cycles;
    logic [31:0] r_perf_flushes;

    // Saturating event counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perf_stall_cycles <= '0;
            r_perf_flushes      <= '0;
        end else begin
            if (w_stall && (r_perf_stall_cycles != 32'hFFFF_FFFF)) begin
                r_perf_stall_cycles <= r_perf_stall_cycles + 32'd1;
            end
            if (w_flush && (r_perf_flushes != 32'hFFFF_FFFF)) begin
                r_perf_flushes <= r_perf_flushes + 32'd1;
            end
        end
    end

    assign perf_stall_cycles = r_perf_stall_cycles;
    assign perf_flushes      = r_perf_flushes;
`endif

endmodule : hazard_stall_controller
`default_nettype wire
